// File: rtl/io_port_pkg.sv
// io_port shared definitions: I/O window constants, bus width macros and the
// register decode helper used by the io_port endpoint.

`ifndef IO_PORT_PKG_DEFS
`define IO_PORT_PKG_DEFS
`define IoDataBus 7:0
`define IoAddrBus 17:0
`endif

package io_port_pkg;

  // Base of the I/O window; only bits 17:16 select the window itself.
  localparam logic [17:0] IoBase    = 18'h30000;
  localparam logic [1:0]  IoUartOff = 2'b00;
  localparam logic [2:0]  IoCntOff  = 3'b100;

  // Offset of the program-end / cycle-counter byte 0 register.
  localparam logic [15:0] IoEndOff  = {13'd0, IoCntOff};

  typedef enum logic [1:0] {
    IO_REG_UART,
    IO_REG_CNT,
    IO_REG_OTHER
  } io_reg_e;

  // Classifies an offset inside the I/O window.
  function automatic io_reg_e decode_reg(input logic [15:0] off);
    if (off == {14'd0, IoUartOff}) return IO_REG_UART;
    if (off[15:2] == {13'd0, IoCntOff[2]}) return IO_REG_CNT;
    return IO_REG_OTHER;
  endfunction

endpackage

// File: rtl/io_fifo.sv
// io_fifo: byte FIFO with wrap-bit pointers. A push on a full FIFO is only
// accepted when a pop happens in the same cycle; a pop on empty is ignored.

module io_fifo #(
  parameter int AW = 4
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          push,
  input  logic [7:0]    push_data,
  input  logic          pop,
  output logic [7:0]    head,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  logic [7:0]  mem [0:(1<<AW)-1];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        push_ok;
  logic        pop_ok;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count   = wr_ptr - rd_ptr;
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign head    = mem[rd_ptr[AW-1:0]];

  // Pointer update; reset empties the FIFO regardless of same-cycle traffic.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write for accepted pushes.
  always_ff @(posedge clk_in) begin
    if (rst_in && push_ok) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/io_port.sv
// io_port: memory-mapped I/O endpoint on the CPU byte bus. Decodes the
// 0x3xxxx window, buffers UART TX/RX bytes, runs the 32-bit cycle counter and
// flags program end. Optional macro IO_CNT_SNAPSHOT_EN makes 4-byte counter
// reads coherent by latching the counter on the byte-0 read.

module io_port
  import io_port_pkg::*;
#(
  parameter int TX_AW       = 4,
  parameter int RX_AW       = 4,
  parameter int FULL_MARGIN = 2
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               rdy_in,
  input  logic [31:0]        mem_a,
  input  logic [`IoDataBus]  mem_dout,
  input  logic               mem_wr,
  output logic [`IoDataBus]  io_din,
  output logic               io_sel,
  output logic               io_buffer_full,
  output logic [7:0]         tx_data,
  output logic               tx_valid,
  input  logic               tx_ready,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  output logic               rx_ready,
  output logic               program_end,
  output logic               tx_overflow
);

  localparam int TX_DEPTH = 1 << TX_AW;

  logic [`IoAddrBus] addr;
  logic              unused_addr_hi;
  logic              access;
  io_reg_e           reg_sel;
  logic              wr_uart, wr_end, rd_any, rd_uart, rd_cnt;
  logic              tx_push, tx_pop, tx_full, tx_empty;
  logic [7:0]        tx_push_data;
  logic [TX_AW:0]    tx_count;
  logic              rx_full, rx_empty;
  logic [7:0]        rx_head;
  logic [RX_AW:0]    rx_count_unused;
  logic [31:0]       counter;
  logic [31:0]       cnt_view;
  logic [7:0]        cnt_byte;
  logic [7:0]        rd_byte;
  int                tx_free;

  assign addr           = mem_a[17:0];
  assign unused_addr_hi = ^{mem_a[31:18], rx_count_unused};
  assign access         = rdy_in && (addr[17:16] == IoBase[17:16]);
  assign reg_sel        = decode_reg(addr[15:0]);

  assign wr_uart = access && mem_wr && (reg_sel == IO_REG_UART);
  assign wr_end  = access && mem_wr && (addr[15:0] == IoEndOff);
  assign rd_any  = access && !mem_wr;
  assign rd_uart = rd_any && (reg_sel == IO_REG_UART);
  assign rd_cnt  = rd_any && (reg_sel == IO_REG_CNT);

  // The program-end write injects a 0x00 terminator past the zero filter.
  assign tx_push      = (wr_uart && (mem_dout != 8'h00)) || wr_end;
  assign tx_push_data = wr_end ? 8'h00 : mem_dout;
  assign tx_valid     = !tx_empty;
  assign tx_pop       = tx_valid && tx_ready;
  assign rx_ready     = !rx_full;

  assign tx_free        = TX_DEPTH - int'(tx_count);
  assign io_buffer_full = (tx_free <= FULL_MARGIN);

  io_fifo #(.AW(TX_AW)) u_tx_fifo (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .push      (tx_push),
    .push_data (tx_push_data),
    .pop       (tx_pop),
    .head      (tx_data),
    .full      (tx_full),
    .empty     (tx_empty),
    .count     (tx_count)
  );

  io_fifo #(.AW(RX_AW)) u_rx_fifo (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .push      (rx_valid && rx_ready),
    .push_data (rx_data),
    .pop       (rd_uart),
    .head      (rx_head),
    .full      (rx_full),
    .empty     (rx_empty),
    .count     (rx_count_unused)
  );

`ifdef IO_CNT_SNAPSHOT_EN
  logic [31:0] snapshot;

  // Latch the whole counter on a byte-0 read so bytes 1..3 stay coherent.
  always_ff @(posedge clk_in) begin
    if (!rst_in) snapshot <= '0;
    else if (rd_cnt && (addr[1:0] == 2'b00)) snapshot <= counter;
  end

  assign cnt_view = (addr[1:0] == 2'b00) ? counter : snapshot;
`else
  assign cnt_view = counter;
`endif

  // Little-endian byte select of the counter view, then the read-data mux.
  always_comb begin
    cnt_byte = cnt_view[7:0];
    case (addr[1:0])
      2'd1:    cnt_byte = cnt_view[15:8];
      2'd2:    cnt_byte = cnt_view[23:16];
      2'd3:    cnt_byte = cnt_view[31:24];
      default: cnt_byte = cnt_view[7:0];
    endcase
    rd_byte = 8'h00;
    if (rd_uart && !rx_empty) rd_byte = rx_head;
    else if (rd_cnt)          rd_byte = cnt_byte;
  end

  // Registered bus response, counter, program-end pulse and sticky overflow.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      counter     <= '0;
      io_din      <= '0;
      io_sel      <= 1'b0;
      program_end <= 1'b0;
      tx_overflow <= 1'b0;
    end else begin
      counter     <= counter + 32'd1;
      io_din      <= rd_byte;
      io_sel      <= rd_any;
      program_end <= wr_end;
      if (tx_push && tx_full && !tx_pop) tx_overflow <= 1'b1;
    end
  end

endmodule

// File: doc/io_port.md
Name: io_port

Overview:
- Memory-mapped I/O endpoint downstream of the CPU byte bus (mem_a / mem_dout / mem_wr).
- Decodes the I/O window (mem_a[17:16]==2'b11) and buffers UART TX/RX bytes in FIFOs.
- Maintains the 32-bit cycle counter and signals program stop.
- Generates io_buffer_full back to the CPU; its read byte is muxed with RAM data by the platform one cycle after the request.

Parameters:
- TX_AW, 4, log2 TX FIFO depth (16 entries)
- RX_AW, 4, log2 RX FIFO depth
- FULL_MARGIN, 2, io_buffer_full asserts when TX free slots <= FULL_MARGIN

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  synchronous active-low reset
- rdy_in  in  1  bus qualifier; when low, no bus access is taken and the counter still runs
- mem_a  in  32  CPU address; only [17:0] decoded
- mem_dout  in  8  CPU write byte
- mem_wr  in  1  1 = write, 0 = read
- io_din  out  8  registered read byte for the CPU
- io_sel  out  1  registered; 1 = io_din is valid this cycle and the platform mux selects it
- io_buffer_full  out  1  back-pressure to CPU
- tx_data  out  8  UART TX byte (FIFO head)
- tx_valid  out  1  TX FIFO non-empty
- tx_ready  in  1  UART accepts the head byte when tx_valid&tx_ready
- rx_data  in  8  UART RX byte
- rx_valid  in  1  push rx_data into RX FIFO
- rx_ready  out  1  RX FIFO not full
- program_end  out  1  one-cycle pulse on write to 0x30004
- tx_overflow  out  1  sticky; a TX byte was dropped

Behaviour:
- Reset (rst_in==0 at posedge):
  - FIFOs empty; counter=0.
  - io_din=0, io_sel=0, program_end=0, tx_overflow=0, io_buffer_full=0.
  - Reset overrides any same-cycle access.
- An access is taken when rdy_in==1 and mem_a[17:16]==2'b11. Other addresses are ignored and io_sel=0 next cycle.
- Cycle counter:
  - Increments every cycle after reset regardless of rdy_in.
  - Wraps 0xFFFFFFFF -> 0.
- Write 0x30000:
  - Byte 0x00 is ignored.
  - Any other byte pushes into the TX FIFO.
  - If the TX FIFO is full, the byte is dropped and tx_overflow sets.
- Write 0x30004:
  - program_end=1 next cycle.
  - 0x00 is pushed to the TX FIFO; the zero filter is bypassed and the full rule is the same as above.
- Other I/O write offsets are ignored.
- Read latency is 1 cycle: io_sel=1 and io_din are valid at cycle N+1 for a request at N.
  - Read 0x30000: pops the RX head. If RX is empty, returns 0x00 and nothing is popped.
  - Read 0x30004..0x30007: returns counter byte mem_a[1:0], little-endian (0x30004 = bits 7:0).
  - Other I/O read offsets return 0x00.
- TX FIFO:
  - Pop on tx_valid&tx_ready.
  - Simultaneous push and pop on a full FIFO is accepted: count unchanged, no overflow.
- RX FIFO:
  - Push on rx_valid&rx_ready; rx_valid while full is dropped silently.
  - Simultaneous CPU pop and UART push on an empty FIFO: the read returns 0x00 and the pushed byte is retained.
- io_buffer_full = (TX_DEPTH - tx_count) <= FULL_MARGIN; combinational from the registered count.
- Pointers: TX_AW+1 / RX_AW+1 bits with a wrap bit. full = MSB differs and the rest equal; empty = pointers equal.

Optional Feature:
- Macro: IO_CNT_SNAPSHOT_EN.
- Defined:
  - A read of 0x30004 latches the full 32-bit counter into a snapshot register and returns its byte 0.
  - Reads of 0x30005..0x30007 return bytes 1..3 of the snapshot, so a 4-byte read is coherent.
  - Snapshot resets to 0.
- Undefined: every byte is taken from the live counter at the request cycle.

Decomposition:
- Shared package/defines header:
  - IoBase 18'h30000, IoUartOff 2'b00, IoCntOff 3'b100.
  - Width macros: IoDataBus [7:0], IoAddrBus [17:0].
- Sub-module io_fifo (param AW, width 8): push/pop/full/empty/count, instantiated for TX and RX.

Test Plan:
- Reset then write 0x41 to 0x30000 -> tx_valid=1 and tx_data=0x41 next cycle; write 0x00 to 0x30000 -> TX count unchanged.
- tx_ready=0, 14 writes -> io_buffer_full=1 after the 14th (16-14 = 2 <= 2); 3 further writes -> 2 pushed, 1 dropped, tx_overflow=1.
- rx_valid pushes 0x55 then 0x66; read 0x30000 twice -> io_din 0x55 then 0x66 with io_sel=1 one cycle after each request; third read -> 0x00.
- 100 cycles after reset, read 0x30004..0x30007 back-to-back:
  - With IO_CNT_SNAPSHOT_EN: bytes equal {0,0,0,C}, where C is the counter value at the first read.
  - Without it: byte 0 tracks the live counter at each request.
- Write 0x30004 -> program_end pulses 1 cycle; TX FIFO gains 0x00; addresses below 0x30000 cause no io_sel.
- rdy_in=0 with a valid I/O write -> no push; rst_in=0 mid-transfer -> FIFOs empty and counter=0 next cycle.
